dram_rd_arbiter: RTL

//  Two-port round-robin arbiter that shares the single DRAM read master (kick/busy/read_num/read_addr,
//  buf_dout/buf_we return) between two read requesters, e.g. filter copy engine (port 0) and display

---
 rtl/dram_rd_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dram_rd_arbiter.sv
// Round-robin arbiter sharing one DRAM read master between two requesters.
// Owns one burst at a time, steers return beats to the winner, checks beat count.
module dram_rd_arbiter #(
    parameter logic [31:0] TIMEOUT_CYC = 32'd4096,
    parameter logic        PRIO_INIT   = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        s0_kick,
    output logic        s0_busy,
    input  logic [31:0] s0_read_num,
    input  logic [31:0] s0_read_addr,
    output logic [31:0] s0_buf_dout,
    output logic        s0_buf_we,
    input  logic        s1_kick,
    output logic        s1_busy,
    input  logic [31:0] s1_read_num,
    input  logic [31:0] s1_read_addr,
    output logic [31:0] s1_buf_dout,
    output logic        s1_buf_we,
    output logic        m_kick,
    input  logic        m_busy,
    output logic [31:0] m_read_num,
    output logic [31:0] m_read_addr,
    input  logic [31:0] m_buf_dout,
    input  logic        m_buf_we,
    output logic        err_len,
    output logic        err_timeout,
    output logic        err_stray,
    input  logic        err_clr,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        prio_q, prio_d;
    logic        m_kick_q, m_kick_d;
    logic        s0_busy_q, s0_busy_d;
    logic        s1_busy_q, s1_busy_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] num_q, num_d;
    logic [31:0] beat_q, beat_d;
    logic [31:0] tmo_q, tmo_d;
    logic        tmo_hit_q, tmo_hit_d;
    logic        err_len_q, err_len_d;
    logic        err_timeout_q, err_timeout_d;
    logic        err_stray_q, err_stray_d;
    logic [15:0] gcnt0_q, gcnt0_d;
    logic [15:0] gcnt1_q, gcnt1_d;
    logic        active;
    logic        sel;
    logic [31:0] beat_nxt;

    assign active   = (state_q != S_IDLE);
    assign beat_nxt = beat_q + {31'd0, m_buf_we};

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        prio_d        = prio_q;
        m_kick_d      = m_kick_q;
        s0_busy_d     = s0_busy_q;
        s1_busy_d     = s1_busy_q;
        addr_d        = addr_q;
        num_d         = num_q;
        beat_d        = beat_q;
        tmo_d         = tmo_q;
        tmo_hit_d     = tmo_hit_q;
        gcnt0_d       = gcnt0_q;
        gcnt1_d       = gcnt1_q;
        sel           = 1'b0;
        err_len_d     = err_clr ? 1'b0 : err_len_q;
        err_timeout_d = err_clr ? 1'b0 : err_timeout_q;
        err_stray_d   = err_clr ? 1'b0 : err_stray_q;
        unique case (state_q)
            S_IDLE: begin
                if (m_buf_we) err_stray_d = 1'b1;
                if (s0_kick || s1_kick) begin
                    // both requesting: prio_q holds the port not served last
                    sel       = (s0_kick && s1_kick) ? prio_q : s1_kick;
                    gnt_d     = sel;
                    addr_d    = sel ? s1_read_addr : s0_read_addr;
                    num_d     = sel ? s1_read_num : s0_read_num;
                    beat_d    = 32'd0;
                    tmo_d     = 32'd0;
                    tmo_hit_d = 1'b0;
                    m_kick_d  = 1'b1;
                    s0_busy_d = ~sel;
                    s1_busy_d = sel;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                beat_d = beat_nxt;
                if (m_busy) begin
                    m_kick_d = 1'b0;
                    state_d  = S_BUSY;
                end else if (TIMEOUT_CYC != 32'd0 &&
                             tmo_q + 32'd1 == TIMEOUT_CYC) begin
                    err_timeout_d = 1'b1;
                    tmo_hit_d     = 1'b1;
                    m_kick_d      = 1'b0;
                    s0_busy_d     = 1'b0;
                    s1_busy_d     = 1'b0;
                    state_d       = S_DONE;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            S_BUSY: begin
                beat_d = beat_nxt;
                if (!m_busy) begin
                    s0_busy_d = 1'b0;
                    s1_busy_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                beat_d = beat_nxt;
                if (!tmo_hit_q && beat_nxt != num_q) err_len_d = 1'b1;
                if (gnt_q) gcnt1_d = gcnt1_q + 16'd1;
                else       gcnt0_d = gcnt0_q + 16'd1;
                prio_d  = ~gnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= S_IDLE;
            gnt_q         <= 1'b0;
            prio_q        <= PRIO_INIT;
            m_kick_q      <= 1'b0;
            s0_busy_q     <= 1'b0;
            s1_busy_q     <= 1'b0;
            addr_q        <= 32'd0;
            num_q         <= 32'd0;
            beat_q        <= 32'd0;
            tmo_q         <= 32'd0;
            tmo_hit_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_stray_q   <= 1'b0;
            gcnt0_q       <= 16'd0;
            gcnt1_q       <= 16'd0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            prio_q        <= prio_d;
            m_kick_q      <= m_kick_d;
            s0_busy_q     <= s0_busy_d;
            s1_busy_q     <= s1_busy_d;
            addr_q        <= addr_d;
            num_q         <= num_d;
            beat_q        <= beat_d;
            tmo_q         <= tmo_d;
            tmo_hit_q     <= tmo_hit_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
            err_stray_q   <= err_stray_d;
            gcnt0_q       <= gcnt0_d;
            gcnt1_q       <= gcnt1_d;
        end
    end

    assign m_kick      = m_kick_q;
    assign m_read_addr = addr_q;
    assign m_read_num  = num_q;
    assign s0_busy     = s0_busy_q;
    assign s1_busy     = s1_busy_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_timeout_q;
    assign err_stray   = err_stray_q;
    assign grant_cnt0  = gcnt0_q;
    assign grant_cnt1  = gcnt1_q;

    // return path is combinational so beats reach the winner in the same cycle
    assign s0_buf_we   = m_buf_we & active & ~gnt_q;
    assign s1_buf_we   = m_buf_we & active & gnt_q;
    assign s0_buf_dout = s0_buf_we ? m_buf_dout : 32'd0;
    assign s1_buf_dout = s1_buf_we ? m_buf_dout : 32'd0;

endmodule
